mcbsp_slave_tx: RTL and testbench
=================================

// Module: mcbsp_slave_tx
// PURPOSE
//  McBSP slave transmitter: serializes stream words onto McBSP_tx, framed by the external master's McBSP_clk/McBSP_fs.
//  Raw pin inputs are synchronized into aclk (125 MHz; McBSP_clk <= 25 MHz) and edge-detected.
//  Feeds the TX/FSX/FRM/CLKR inputs of the McBSP pin-buffer block; sources data from the PS data-transport stream.
// PARAMETERS
//  WORD_BITS        32  bits per word, shifted MSB first
//  WORDS_PER_FRAME  4   words per frame
//  DATA_DELAY       1   McBSP_clk rising edges from FS sample to first bit; legal values 1 or 2
// PORTS
//  aclk           in   1          system clock
//  aresetn        in   1          synchronous active-low reset
//  enable         in   1          arm frame acceptance
//  McBSP_clk      in   1          McBSP bit clock from master, asynchronous
//  McBSP_fs       in   1          McBSP frame sync from master, asynchronous
//  s_axis_tdata   in   WORD_BITS  word to send
//  s_axis_tvalid  in   1          word valid
//  s_axis_tready  out  1          holding register empty
//  McBSP_tx       out  1          serial data out
//  McBSP_fsx      out  1          frame-start pulse (debug)
//  McBSP_frm      out  1          in-frame flag (debug)
//  McBSP_clkr     out  1          returned, synchronized bit clock (debug)
//  frame_count    out  32         completed frames, wraps at 2^32
//  underrun       out  1          sticky: a word slot found the holding register empty
// BEHAVIOUR
//  - Reset: every output is 0, the FSM is in IDLE, and the holding register is empty.
//  - Reset: s_axis_tready is 0 during reset and 1 on the first cycle after release.
//  - Synchronization: McBSP_clk and McBSP_fs each pass a 2-FF synchronizer.
//  - Edges: rise = clk_s & ~clk_d; fall = ~clk_s & clk_d.
//  - Timing: McBSP_tx updates 3 aclk after a pin rising edge.
//  - Holding register: s_axis_tready = ~hold_valid, registered.
//  - Holding register: tvalid & tready sets hold_valid; a word load clears it.
//  - Holding register: no same-cycle refill; tready goes high the cycle after the load.
//  - FSM IDLE: on fall with fs_s=1 and enable=1, go to DELAY with dcnt = DATA_DELAY-1.
//  - FSM DELAY: on each rise, when dcnt==0, load the first word and go to SHIFT; otherwise decrement dcnt.
//  - FSM SHIFT: on each rise, drive the next bit MSB first; each bit is held until the next rise.
//  - FSM SHIFT: the bit and word counters advance on rise only.
//  - Word load at each word boundary: if hold_valid, shreg = hold.
//  - Word load at each word boundary: otherwise shreg = 0 and underrun is set to 1.
//  - underrun is cleared by reset only.
//  - End of frame: on the rise after the last bit (WORD_BITS*WORDS_PER_FRAME bits), McBSP_tx = 0.
//  - End of frame: frame_count increments and the FSM returns to IDLE.
//  - FS sampled high in DELAY or SHIFT is ignored; the frame is not restarted.
//  - enable low mid-frame: the current frame completes; the next FS is ignored.
//  - Back-to-back frames: FS on the fall right after the last bit is accepted.
//  - Reset mid-frame: tx is 0 next cycle, the FSM is in IDLE, the holding register is flushed, and frame_count is 0.
// CONFIGURATION
//  MCBSP_TX_DEBUG_EN defined:
//   - McBSP_fsx is a 1-aclk pulse on the cycle DELAY->SHIFT.
//   - McBSP_frm is 1 while in SHIFT.
//   - McBSP_clkr = clk_s.
//  MCBSP_TX_DEBUG_EN undefined: McBSP_fsx, McBSP_frm and McBSP_clkr are tied to 0 with no logic.
// TESTING
//  1. Reset held 10 cycles, then released -> all outputs 0; tready=1 on the 1st cycle after release.
//  2. Frame with data ready:
//     - Stimulus: 20 MHz McBSP_clk; words 0xA5A50001, 0x0000FFFF, 0x80000000, 0x12345678 streamed; one-bit-time FS.
//     - Response: 128 bits MSB first, starting 1 rise after the FS sample; frame_count=1; underrun=0.
//  3. Underrun: only 2 words supplied -> words 3 and 4 are transmitted as 0; underrun=1; frame_count=1.
//  4. Stray FS: FS pulsed at bit 50 of a frame -> bit stream identical to test 2; frame_count=1.
//  5. Reset mid-frame: aresetn low at bit 40 -> tx=0 and frame_count=0.
//     The next FS with fresh data sends a complete frame from bit 0.
//  6. DATA_DELAY=2: first bit appears on the 2nd rise after the FS sample.
//     With MCBSP_TX_DEBUG_EN: frm is high for exactly 128 bit-times and fsx pulses once.

Source files
------------

// File: rtl/mcbsp_slave_tx.sv
// mcbsp_slave_tx: McBSP slave transmitter, serializes stream words framed by an external master's clk/fs.
// Define MCBSP_TX_DEBUG_EN to drive McBSP_fsx/McBSP_frm/McBSP_clkr; otherwise they are tied to 0.
module mcbsp_slave_tx #(
  parameter int WORD_BITS = 32,
  parameter int WORDS_PER_FRAME = 4,
  parameter int DATA_DELAY = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 McBSP_clk,
  input  logic                 McBSP_fs,
  input  logic [WORD_BITS-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic                 McBSP_tx,
  output logic                 McBSP_fsx,
  output logic                 McBSP_frm,
  output logic                 McBSP_clkr,
  output logic [31:0]          frame_count,
  output logic                 underrun
);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int WW = $clog2(WORDS_PER_FRAME + 1);
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} stateT;
  stateT state, nextState;
  logic clkMeta, clkS, clkD, fsMeta, fsS, rise, fall;
  logic [1:0] dcnt;
  logic [BW-1:0] bitCnt;
  logic [WW-1:0] wordCnt;
  logic [WORD_BITS-1:0] shreg, hold, loadWord;
  logic holdValid, holdValidNext, accept, wordDone, lastWord;
  logic start, load, shift, endFrame;
  always_ff @(posedge aclk)
    if (!aresetn) {clkMeta, clkS, clkD, fsMeta, fsS} <= '0;
    else {clkMeta, clkS, clkD, fsMeta, fsS} <= {McBSP_clk, clkMeta, clkS, McBSP_fs, fsMeta};
  assign rise = clkS & ~clkD;
  assign fall = ~clkS & clkD;
  assign wordDone = bitCnt == BW'(WORD_BITS);
  assign lastWord = wordCnt == WW'(WORDS_PER_FRAME - 1);
  assign loadWord = holdValid ? hold : '0;
  assign accept = s_axis_tvalid & s_axis_tready;
  // a load and an accept may coincide only when the register was already empty
  assign holdValidNext = accept | (holdValid & ~load);
  always_ff @(posedge aclk)
    if (!aresetn) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = start ? DELAY : load ? SHIFT : endFrame ? IDLE : state;
  always_comb begin
    start = state == IDLE && fall && fsS && enable;
    load = rise && ((state == DELAY && dcnt == 2'd0) || (state == SHIFT && wordDone && !lastWord));
    shift = rise && state == SHIFT && !wordDone;
    endFrame = rise && state == SHIFT && wordDone && lastWord;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dcnt <= '0;
      bitCnt <= '0;
      wordCnt <= '0;
      shreg <= '0;
      hold <= '0;
      holdValid <= 1'b0;
      s_axis_tready <= 1'b0;
      McBSP_tx <= 1'b0;
      frame_count <= '0;
      underrun <= 1'b0;
    end else begin
      if (start) dcnt <= 2'(DATA_DELAY - 1);
      else if (rise && state == DELAY && dcnt != 2'd0) dcnt <= dcnt - 2'd1;
      if (load) begin
        McBSP_tx <= loadWord[WORD_BITS-1];
        shreg <= loadWord << 1;
        bitCnt <= BW'(1);
        wordCnt <= state == DELAY ? '0 : wordCnt + WW'(1);
        underrun <= underrun | ~holdValid;
      end else if (shift) begin
        McBSP_tx <= shreg[WORD_BITS-1];
        shreg <= shreg << 1;
        bitCnt <= bitCnt + BW'(1);
      end else if (endFrame) begin
        McBSP_tx <= 1'b0;
        frame_count <= frame_count + 32'd1;
      end
      if (accept) hold <= s_axis_tdata;
      holdValid <= holdValidNext;
      s_axis_tready <= ~holdValidNext;
    end
  end
`ifdef MCBSP_TX_DEBUG_EN
  assign McBSP_fsx = state == DELAY && nextState == SHIFT;
  assign McBSP_frm = state == SHIFT;
  assign McBSP_clkr = clkS;
`else
  assign McBSP_fsx = 1'b0;
  assign McBSP_frm = 1'b0;
  assign McBSP_clkr = 1'b0;
`endif
endmodule

// File: tb/tb_mcbsp_slave_tx.sv
// tb_mcbsp_slave_tx: random-data bench for mcbsp_slave_tx, checked against a word-queue frame model.
module tb_mcbsp_slave_tx;
  logic aclk = 0, aresetn = 0, enable = 0, McBSP_clk = 0, McBSP_fs = 0, s_axis_tvalid = 0;
  logic [31:0] s_axis_tdata = 0;
  logic s_axis_tready, McBSP_tx, McBSP_fsx, McBSP_frm, McBSP_clkr, underrun;
  logic [31:0] frame_count;
  logic tready2, tx2, fsx2, frm2, clkr2, ur2;
  logic [31:0] fc2;
  int total = 0, bad = 0, fsxCnt = 0;
  logic [31:0] feedQ[$], expQ[$];
  logic [31:0] expFc = 0;
  logic got[0:139], got2[0:139], frmS[0:139];
  logic rdy = 0;
`ifdef MCBSP_TX_DEBUG_EN
  localparam int DBG = 1;
`else
  localparam int DBG = 0;
`endif
  mcbsp_slave_tx dut (.aclk(aclk), .aresetn(aresetn), .enable(enable), .McBSP_clk(McBSP_clk),
    .McBSP_fs(McBSP_fs), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .McBSP_tx(McBSP_tx), .McBSP_fsx(McBSP_fsx), .McBSP_frm(McBSP_frm),
    .McBSP_clkr(McBSP_clkr), .frame_count(frame_count), .underrun(underrun));
  mcbsp_slave_tx #(.DATA_DELAY(2)) dut2 (.aclk(aclk), .aresetn(aresetn), .enable(enable),
    .McBSP_clk(McBSP_clk), .McBSP_fs(McBSP_fs), .s_axis_tdata(32'hFFFF_FFFF), .s_axis_tvalid(1'b1),
    .s_axis_tready(tready2), .McBSP_tx(tx2), .McBSP_fsx(fsx2), .McBSP_frm(frm2),
    .McBSP_clkr(clkr2), .frame_count(fc2), .underrun(ur2));
  always #4 aclk = ~aclk;
  always @(negedge aclk) if (fsx2) fsxCnt <= fsxCnt + 1;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, act, exp);
    end
  endtask
  // stream source: a handshake seen at one posedge retires the queue head at the next negedge
  initial forever begin
    @(negedge aclk);
    if (s_axis_tvalid && rdy && feedQ.size() > 0) void'(feedQ.pop_front());
    s_axis_tvalid = feedQ.size() > 0;
    s_axis_tdata = feedQ.size() > 0 ? feedQ[0] : 32'd0;
    rdy = s_axis_tready;
  end
  task automatic push(input logic [31:0] w);
    feedQ.push_back(w);
    expQ.push_back(w);
  endtask
  // one 50 ns bit period: fs changes on the rising edge, tx sampled just before the next rise
  task automatic tick(input logic fs, input int j);
    McBSP_clk = 1;
    McBSP_fs = fs;
    #25;
    McBSP_clk = 0;
    #24;
    got[j] = McBSP_tx;
    got2[j] = tx2;
    frmS[j] = frm2;
    #1;
  endtask
  task automatic frame(input bit fsFirst, input bit fsLast, input int stray, input int nWords,
                       input int dropAt, input string tag);
    logic [31:0] rw, ew;
    if (fsFirst) begin
      tick(1, 0);
      chk({tag, "_idle"}, got[0], 0);
    end
    for (int j = 1; j <= 129; j++) begin
      if (j == dropAt) enable = 0;
      tick((j == stray) || (j == 129 && fsLast), j);
    end
    for (int w = 0; w < 4; w++) begin
      rw = '0;
      for (int b = 0; b < 32; b++) rw = {rw[30:0], got[1 + 32 * w + b]};
      ew = '0;
      if (w < nWords && expQ.size() > 0) ew = expQ.pop_front();
      chk($sformatf("%s_w%0d", tag, w), rw, ew);
    end
    chk({tag, "_tail"}, got[129], 0);
    expFc++;
    chk({tag, "_fc"}, frame_count, expFc);
  endtask
  initial begin
    logic [31:0] rw;
    int ones, frmN;
    logic any;
    repeat (10) @(negedge aclk);
    chk("rst_tx", McBSP_tx, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_ur", underrun, 0);
    chk("rst_dbg", {McBSP_fsx, McBSP_frm, McBSP_clkr}, 0);
    aresetn = 1;
    @(negedge aclk);
    chk("rel_tready", s_axis_tready, 1);
    enable = 1;
    push(32'hA5A5_0001);
    push(32'h0000_FFFF);
    push(32'h8000_0000);
    push(32'h1234_5678);
    repeat (20) @(negedge aclk);
    #1;
    frame(1, 0, -1, 4, -1, "fixed");
    chk("fixed_ur", underrun, 0);
    ones = 0;
    frmN = 0;
    for (int j = 2; j <= 129; j++) ones += int'(got2[j]);
    for (int j = 1; j <= 129; j++) frmN += int'(frmS[j]);
    chk("dd2_first_rise", got2[1], 0);
    chk("dd2_bits", ones, 128);
    chk("dd2_frm_bits", frmN, DBG ? 128 : 0);
    chk("dd2_fsx_pulses", fsxCnt, DBG ? 1 : 0);
    for (int i = 0; i < 8; i++) push($urandom);
    repeat (20) @(negedge aclk);
    #1;
    frame(1, 1, 51, 4, -1, "stray");
    frame(0, 0, -1, 4, -1, "b2b");
    for (int i = 0; i < 4; i++) push($urandom);
    repeat (20) @(negedge aclk);
    #1;
    frame(1, 0, -1, 4, $urandom_range(20, 110), "endrop");
    tick(1, 130);
    for (int j = 131; j < 135; j++) tick(0, j);
    any = 0;
    for (int j = 131; j < 135; j++) any |= got[j];
    chk("endis_tx", any, 0);
    chk("endis_fc", frame_count, expFc);
    enable = 1;
    for (int i = 0; i < 4; i++) push($urandom);
    repeat (20) @(negedge aclk);
    #1;
    tick(1, 0);
    for (int j = 1; j <= 40; j++) tick(0, j);
    rw = '0;
    for (int b = 0; b < 32; b++) rw = {rw[30:0], got[1 + b]};
    chk("mid_w0", rw, expQ[0]);
    feedQ.delete();
    expQ.delete();
    repeat (2) @(negedge aclk);
    aresetn = 0;
    @(negedge aclk);
    chk("mid_rst_tx", McBSP_tx, 0);
    chk("mid_rst_fc", frame_count, 0);
    repeat (5) @(negedge aclk);
    aresetn = 1;
    expFc = 0;
    for (int i = 0; i < 4; i++) push($urandom);
    repeat (20) @(negedge aclk);
    #1;
    frame(1, 0, -1, 4, -1, "fresh");
    chk("fresh_ur", underrun, 0);
    for (int i = 0; i < 2; i++) push($urandom);
    repeat (20) @(negedge aclk);
    #1;
    frame(1, 0, -1, 2, -1, "under");
    chk("under_ur", underrun, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
